// File: rtl/note_select.sv
// Key bank to tone frequency: 2-flop sync, per-key debounce, priority select,
// octave scaling with saturation, and a registered output with change pulse.
module note_select #(
    parameter int NUM_KEYS        = 8,
    parameter int FREQ_W          = 12,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PRIORITY_MODE   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [1:0]          octave,
    output logic [FREQ_W-1:0]   freq,
    output logic [2:0]          note_idx,
    output logic                note_active,
    output logic                note_change
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] MAX_F = 32'((64'd1 << FREQ_W) - 64'd1);

    logic [NUM_KEYS-1:0] s1, sk, db, db_nxt, rise;
    logic [CNT_W-1:0]    cnt     [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_KEYS];
    logic [2:0]          last, rise_idx, low_idx, sel;
    logic [7:0]          db8;
    logic                any_key;
    logic [13:0]         base, scaled;
    logic [31:0]         wide;
    logic [FREQ_W-1:0]   freq_nxt;
    logic [2:0]          idx_nxt;

    function automatic logic [13:0] base_of(input logic [2:0] k);
        case (k)
            3'd0:    base_of = 14'd440;
            3'd1:    base_of = 14'd493;
            3'd2:    base_of = 14'd523;
            3'd3:    base_of = 14'd587;
            3'd4:    base_of = 14'd659;
            3'd5:    base_of = 14'd698;
            3'd6:    base_of = 14'd783;
            default: base_of = 14'd880;
        endcase
    endfunction

    // Counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
        db_nxt = db;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_nxt[i] = '0;
            if (sk[i] != db[i]) begin
                if (cnt[i] == CNT_MAX) db_nxt[i] = sk[i];
                else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    assign rise = db_nxt & ~db;

    always_comb begin
        rise_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (rise[i]) rise_idx = 3'(i);
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (db[i]) low_idx = 3'(i);
    end

    assign db8     = 8'(db);
    assign any_key = |db;

    // db[last] low covers both "last released" and "nothing held".
    always_comb begin
        sel = low_idx;
        if (PRIORITY_MODE == 1 && db8[last]) sel = last;
    end

    always_comb begin
        base = base_of(sel);
        case (octave)
            2'd0:    scaled = base;
            2'd1:    scaled = base << 1;
            2'd2:    scaled = base << 2;
            default: scaled = base >> 1;
        endcase
        wide = 32'(scaled);
        if (!any_key)          freq_nxt = '0;
        else if (wide > MAX_F) freq_nxt = '1;
        else                   freq_nxt = FREQ_W'(wide);
        idx_nxt = any_key ? sel : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            sk          <= '0;
            db          <= '0;
            last        <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
            freq        <= '0;
            note_idx    <= '0;
            note_active <= 1'b0;
            note_change <= 1'b0;
        end else begin
            s1          <= key_in;
            sk          <= s1;
            db          <= db_nxt;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= cnt_nxt[i];
            if (|rise) last <= rise_idx;
            freq        <= freq_nxt;
            note_idx    <= idx_nxt;
            note_active <= any_key;
            note_change <= (freq_nxt != freq);
        end
    end

endmodule

// File: tb/tb_note_select.sv
// Scoreboard bench: three note_select configurations share stimulus; each
// note_change pulse is popped against the expected queue of its instance.
module tb_note_select;

    typedef struct packed {
        logic [11:0] f;
        logic [2:0]  i;
        logic        a;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_in = '0;
    logic [1:0] octave = '0;

    logic [11:0] f0, f1;
    logic [10:0] f2;
    logic [2:0]  i0, i1, i2;
    logic        a0, a1, a2, nc0, nc1, nc2;

    exp_t q0[$], q1[$], q2[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    note_select #(.NUM_KEYS(8), .FREQ_W(12), .DEBOUNCE_CYCLES(4), .PRIORITY_MODE(0)) u0 (
        .clk(clk), .rst(rst), .key_in(key_in), .octave(octave),
        .freq(f0), .note_idx(i0), .note_active(a0), .note_change(nc0));
    note_select #(.NUM_KEYS(8), .FREQ_W(12), .DEBOUNCE_CYCLES(4), .PRIORITY_MODE(1)) u1 (
        .clk(clk), .rst(rst), .key_in(key_in), .octave(octave),
        .freq(f1), .note_idx(i1), .note_active(a1), .note_change(nc1));
    note_select #(.NUM_KEYS(8), .FREQ_W(11), .DEBOUNCE_CYCLES(4), .PRIORITY_MODE(0)) u2 (
        .clk(clk), .rst(rst), .key_in(key_in), .octave(octave),
        .freq(f2), .note_idx(i2), .note_active(a2), .note_change(nc2));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pulse(input string who, input exp_t e, input logic [11:0] f,
                               input logic [2:0] i, input logic a);
        chk({who, "_freq"}, int'(f), int'(e.f));
        chk({who, "_idx"},  int'(i), int'(e.i));
        chk({who, "_act"},  int'(a), int'(e.a));
    endtask

    task automatic unexpected(input string who, input int f);
        total++;
        bad++;
        $display("FAIL %s_pulse: unexpected note_change with freq %0d, expected none", who, f);
    endtask

    always @(negedge clk) if (nc0) begin
        if (q0.size() == 0) unexpected("u0", int'(f0));
        else check_pulse("u0", q0.pop_front(), f0, i0, a0);
    end
    always @(negedge clk) if (nc1) begin
        if (q1.size() == 0) unexpected("u1", int'(f1));
        else check_pulse("u1", q1.pop_front(), f1, i1, a1);
    end
    always @(negedge clk) if (nc2) begin
        if (q2.size() == 0) unexpected("u2", int'(f2));
        else check_pulse("u2", q2.pop_front(), {1'b0, f2}, i2, a2);
    end

    task automatic push_all(input int f, input int fsat, input int i, input logic a);
        q0.push_back('{12'(f), 3'(i), a});
        q1.push_back('{12'(f), 3'(i), a});
        q2.push_back('{12'(fsat), 3'(i), a});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_f0"}, int'(f0), 0);
        chk({name, "_f1"}, int'(f1), 0);
        chk({name, "_f2"}, int'(f2), 0);
        chk({name, "_act"}, int'({a0, a1, a2}), 0);
        chk({name, "_idx"}, int'({i0, i1, i2}), 0);
    endtask

    initial begin
        cyc(3);
        check_idle("reset");
        chk("reset_nc", int'({nc0, nc1, nc2}), 0);
        rst = 1'b0;

        // Clean press of key 0: registered on edge 7 after the change.
        key_in = 8'b0000_0001;
        push_all(440, 440, 0, 1'b1);
        repeat (6) @(posedge clk);
        #1 chk("lat_edge6_freq", int'(f0), 0);
        @(posedge clk);
        #1 chk("lat_edge7_freq", int'(f0), 440);
        chk("lat_edge7_nc", int'(nc0), 1);
        @(negedge clk);
        cyc(5);

        key_in = 8'h00;
        push_all(0, 0, 0, 1'b0);
        cyc(10);

        // Three-cycle glitch is rejected, four cycles is accepted.
        key_in = 8'b0000_1000;
        cyc(3);
        key_in = 8'h00;
        cyc(12);
        chk("glitch_freq", int'(f0), 0);
        key_in = 8'b0000_1000;
        push_all(587, 587, 3, 1'b1);
        push_all(0, 0, 0, 1'b0);
        cyc(4);
        key_in = 8'h00;
        cyc(15);

        // Priority: key 2, then key 5 added, then key 5 released.
        key_in = 8'b0000_0100;
        push_all(523, 523, 2, 1'b1);
        cyc(10);
        key_in = 8'b0010_0100;
        q1.push_back('{12'd698, 3'd5, 1'b1});
        cyc(10);
        chk("prio_mode0", int'(f0), 523);
        key_in = 8'b0000_0100;
        q1.push_back('{12'd523, 3'd2, 1'b1});
        cyc(10);
        key_in = 8'h00;
        push_all(0, 0, 0, 1'b0);
        cyc(10);

        // Octave scaling on key 7, with saturation on the 11-bit instance.
        key_in = 8'b1000_0000;
        push_all(880, 880, 7, 1'b1);
        cyc(10);
        octave = 2'd1;
        push_all(1760, 1760, 7, 1'b1);
        cyc(4);
        octave = 2'd2;
        push_all(3520, 2047, 7, 1'b1);
        cyc(4);
        octave = 2'd3;
        push_all(440, 440, 7, 1'b1);
        cyc(4);
        octave = 2'd0;
        push_all(880, 880, 7, 1'b1);
        cyc(4);
        key_in = 8'h00;
        push_all(0, 0, 0, 1'b0);
        cyc(10);
        octave = 2'd2;
        cyc(4);
        chk("octave_idle", int'(f0), 0);
        octave = 2'd0;
        cyc(2);

        // Simultaneous rising edges pick the lower index in both modes.
        key_in = 8'b0100_0010;
        push_all(493, 493, 1, 1'b1);
        cyc(10);
        key_in = 8'h00;
        push_all(0, 0, 0, 1'b0);
        cyc(10);

        // Reset mid-debounce discards progress; key 4 needs a full debounce again.
        key_in = 8'b0000_0001;
        push_all(440, 440, 0, 1'b1);
        cyc(10);
        key_in = 8'b0001_0000;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check_idle("rst_mid");
        rst = 1'b0;
        push_all(659, 659, 4, 1'b1);
        repeat (6) @(posedge clk);
        #1 chk("rst_edge6_freq", int'(f0), 0);
        @(posedge clk);
        #1 chk("rst_edge7_freq", int'(f0), 659);
        @(negedge clk);
        cyc(3);
        key_in = 8'h00;
        push_all(0, 0, 0, 1'b0);
        cyc(12);

        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        chk("q2_left", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
